// File: rtl/issue_ctrl.sv
// issue_ctrl: instruction queue between fetch and the back end.
// Fetched {inst, pc} pairs are queued in order; the head word is shown to an
// external combinational decoder, and its decoded fields are issued to either
// the reservation station or the load/store buffer, one per cycle, in order.
// A ROB clear empties the queue and spends one cycle in FLUSH.
module issue_ctrl #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_inst,
    input  logic [31:0] fetch_pc,
    output logic        fetch_ready,
    output logic [31:0] dec_inst,
    input  logic [5:0]  dec_order,
    input  logic [31:0] dec_rd,
    input  logic [31:0] dec_rs1,
    input  logic [31:0] dec_rs2,
    input  logic [31:0] dec_imm,
    input  logic        rob_full,
    input  logic        rs_full,
    input  logic        lsb_full,
    input  logic        clear_in,
    output logic        iss_valid,
    output logic        iss_to_lsb,
    output logic [5:0]  iss_order,
    output logic [4:0]  iss_rd,
    output logic [4:0]  iss_rs1,
    output logic [4:0]  iss_rs2,
    output logic [31:0] iss_imm,
    output logic [31:0] iss_pc,
    output logic        illegal
);

    // Memory-access order codes shared with the decoder.
    localparam logic [5:0] ORD_LB  = 6'd11;
    localparam logic [5:0] ORD_LH  = 6'd12;
    localparam logic [5:0] ORD_LW  = 6'd13;
    localparam logic [5:0] ORD_LBU = 6'd14;
    localparam logic [5:0] ORD_LHU = 6'd15;
    localparam logic [5:0] ORD_SB  = 6'd16;
    localparam logic [5:0] ORD_SH  = 6'd17;
    localparam logic [5:0] ORD_SW  = 6'd18;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [31:0]         inst_mem_r [DEPTH];
    logic [31:0]         pc_mem_r   [DEPTH];
    logic [ADDR_W-1:0]   head_r;
    logic [ADDR_W-1:0]   tail_r;
    logic [ADDR_W:0]     count_r;

    logic                empty_s;
    logic                is_lsb_s;
    logic                push_s;
    logic                head_ok_s;
    logic                issue_s;
    logic                drop_s;
    logic                pop_s;
    logic                unused_ok_s;

    // Only the low five bits of the register fields are meaningful.
    assign unused_ok_s = ^{dec_rd[31:5], dec_rs1[31:5], dec_rs2[31:5]};

    assign empty_s     = (count_r == {(ADDR_W+1){1'b0}});
    // Readiness looks only at registered state, never at the same-cycle pop.
    assign fetch_ready = (state_r == ST_RUN) && (count_r < DEPTH_C);
    assign push_s      = fetch_valid && fetch_ready && rdy_in && !clear_in;
    assign head_ok_s   = (state_r == ST_RUN) && !empty_s && rdy_in && !clear_in;
    assign drop_s      = head_ok_s && (dec_order == 6'd0);
    assign issue_s     = head_ok_s && (dec_order != 6'd0) && !rob_full &&
                         (is_lsb_s ? !lsb_full : !rs_full);
    assign pop_s       = issue_s || drop_s;

    // Head word to the decoder; zero when nothing is queued.
    always_comb begin
        dec_inst = 32'd0;
        if (!empty_s) begin
            dec_inst = inst_mem_r[head_r];
        end else begin
            dec_inst = 32'd0;
        end
    end

    // Classify the decoded order as load/store (LSB) or everything else (RS).
    always_comb begin
        is_lsb_s = 1'b0;
        case (dec_order)
            ORD_LB, ORD_LH, ORD_LW, ORD_LBU, ORD_LHU,
            ORD_SB, ORD_SH, ORD_SW: is_lsb_s = 1'b1;
            default:                is_lsb_s = 1'b0;
        endcase
    end

    // Next-state logic: a clear enters FLUSH, which lasts one ready cycle.
    always_comb begin
        state_nx_s = state_r;
        if (rdy_in) begin
            case (state_r)
                ST_RUN:   state_nx_s = clear_in ? ST_FLUSH : ST_RUN;
                ST_FLUSH: state_nx_s = ST_RUN;
                default:  state_nx_s = ST_RUN;
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Queue storage; contents are only visible through head/count, so no reset.
    always_ff @(posedge clk_in) begin
        if (push_s) begin
            inst_mem_r[tail_r] <= fetch_inst;
            pc_mem_r[tail_r]   <= fetch_pc;
        end
    end

    // Queue pointers and occupancy; a clear discards any same-cycle push/pop.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head_r  <= {ADDR_W{1'b0}};
            tail_r  <= {ADDR_W{1'b0}};
            count_r <= {(ADDR_W+1){1'b0}};
        end else if (rdy_in && clear_in) begin
            head_r  <= {ADDR_W{1'b0}};
            tail_r  <= {ADDR_W{1'b0}};
            count_r <= {(ADDR_W+1){1'b0}};
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PTR_ONE;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Issue register: pulses valid/illegal, data fields hold between issues.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            iss_valid  <= 1'b0;
            illegal    <= 1'b0;
            iss_to_lsb <= 1'b0;
            iss_order  <= 6'd0;
            iss_rd     <= 5'd0;
            iss_rs1    <= 5'd0;
            iss_rs2    <= 5'd0;
            iss_imm    <= 32'd0;
            iss_pc     <= 32'd0;
        end else begin
            iss_valid <= issue_s;
            illegal   <= drop_s;
            if (issue_s) begin
                iss_to_lsb <= is_lsb_s;
                iss_order  <= dec_order;
                iss_rd     <= dec_rd[4:0];
                iss_rs1    <= dec_rs1[4:0];
                iss_rs2    <= dec_rs2[4:0];
                iss_imm    <= dec_imm;
                iss_pc     <= pc_mem_r[head_r];
            end
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: a behavioural decoder drives the dec_* inputs, and a
// queue-based model predicts fetch_ready, dec_inst and the issue outputs.
module tb_issue_ctrl;

    localparam int DEPTH = 16;
    localparam logic [5:0] O_LB = 6'd11, O_LH = 6'd12, O_LW = 6'd13, O_LBU = 6'd14,
                           O_LHU = 6'd15, O_SB = 6'd16, O_SH = 6'd17, O_SW = 6'd18,
                           O_ADDI = 6'd19, O_ADD = 6'd28;

    logic        clk_in = 1'b0;
    logic        rst_n_in, rdy_in, fetch_valid, fetch_ready;
    logic [31:0] fetch_inst, fetch_pc, dec_inst;
    logic [5:0]  dec_order;
    logic [31:0] dec_rd, dec_rs1, dec_rs2, dec_imm;
    logic        rob_full, rs_full, lsb_full, clear_in;
    logic        iss_valid, iss_to_lsb, illegal;
    logic [5:0]  iss_order;
    logic [4:0]  iss_rd, iss_rs1, iss_rs2;
    logic [31:0] iss_imm, iss_pc;

    int checks = 0;
    int failures = 0;

    // model state
    logic [63:0] m_q[$];
    logic        m_flush, m_valid, m_ill, m_lsb;
    logic [5:0]  m_order;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    logic [31:0] m_imm, m_pc;

    always #5 clk_in = ~clk_in;

    issue_ctrl #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .fetch_valid(fetch_valid), .fetch_inst(fetch_inst), .fetch_pc(fetch_pc),
        .fetch_ready(fetch_ready), .dec_inst(dec_inst), .dec_order(dec_order),
        .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_imm(dec_imm),
        .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full), .clear_in(clear_in),
        .iss_valid(iss_valid), .iss_to_lsb(iss_to_lsb), .iss_order(iss_order),
        .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_imm(iss_imm),
        .iss_pc(iss_pc), .illegal(illegal)
    );

    function automatic logic [5:0] f_order(input logic [31:0] w);
        logic [2:0] f3;
        f3 = w[14:12];
        case (w[6:0])
            7'b0000011: case (f3)
                3'd0: return O_LB;  3'd1: return O_LH; 3'd2: return O_LW;
                3'd4: return O_LBU; 3'd5: return O_LHU;
                default: return 6'd0;
            endcase
            7'b0100011: case (f3)
                3'd0: return O_SB; 3'd1: return O_SH; 3'd2: return O_SW;
                default: return 6'd0;
            endcase
            7'b0010011: return (f3 == 3'd0) ? O_ADDI : 6'd0;
            7'b0110011: return (f3 == 3'd0 && w[31:25] == 7'd0) ? O_ADD : 6'd0;
            default:    return 6'd0;
        endcase
    endfunction

    function automatic logic [31:0] f_imm(input logic [31:0] w);
        if (w[6:0] == 7'b0100011) return {{20{w[31]}}, w[31:25], w[11:7]};
        if (w[6:0] == 7'b0110011) return 32'd0;
        return {{20{w[31]}}, w[31:20]};
    endfunction

    function automatic logic f_is_mem(input logic [5:0] o);
        return (o >= O_LB) && (o <= O_SW);
    endfunction

    // External decoder stand-in; upper bits of register fields carry junk.
    always_comb begin
        dec_order = f_order(dec_inst);
        dec_rd    = {27'h5A5A5A5, dec_inst[11:7]};
        dec_rs1   = {27'h7FFFFFF, dec_inst[19:15]};
        dec_rs2   = {27'h2AAAAAA, dec_inst[24:20]};
        dec_imm   = f_imm(dec_inst);
    end

    task automatic model_reset();
        m_q.delete();
        m_flush = 1'b0; m_valid = 1'b0; m_ill = 1'b0; m_lsb = 1'b0;
        m_order = 6'd0; m_rd = 5'd0; m_rs1 = 5'd0; m_rs2 = 5'd0;
        m_imm = 32'd0; m_pc = 32'd0;
    endtask

    // One clock cycle from a negedge: drive, predict, compare, return at negedge.
    task automatic step(input logic fv, input logic [31:0] inst, input logic [31:0] pc,
                        input logic robf, input logic rsf, input logic lsbf,
                        input logic clr, input logic rdy);
        logic        exp_ready;
        logic [31:0] exp_dec, hw;
        logic [5:0]  ord;
        logic [63:0] e;
        fetch_valid = fv; fetch_inst = inst; fetch_pc = pc;
        rob_full = robf; rs_full = rsf; lsb_full = lsbf; clear_in = clr; rdy_in = rdy;
        exp_ready = !m_flush && (m_q.size() < DEPTH);
        exp_dec   = (m_q.size() > 0) ? m_q[0][63:32] : 32'd0;
        #1;
        checks++;
        if (fetch_ready !== exp_ready) begin
            failures++;
            $display("FAIL fetch_ready @%0t got=%b exp=%b", $time, fetch_ready, exp_ready);
        end
        checks++;
        if (dec_inst !== exp_dec) begin
            failures++;
            $display("FAIL dec_inst @%0t got=%h exp=%h", $time, dec_inst, exp_dec);
        end
        m_valid = 1'b0; m_ill = 1'b0;
        if (rdy) begin
            if (m_flush) begin
                m_flush = 1'b0;
            end else if (clr) begin
                m_q.delete();
                m_flush = 1'b1;
            end else begin
                if (m_q.size() > 0) begin
                    hw  = m_q[0][63:32];
                    ord = f_order(hw);
                    if (ord == 6'd0) begin
                        void'(m_q.pop_front());
                        m_ill = 1'b1;
                    end else if (!robf && (f_is_mem(ord) ? !lsbf : !rsf)) begin
                        e = m_q.pop_front();
                        m_valid = 1'b1; m_lsb = f_is_mem(ord); m_order = ord;
                        m_rd = hw[11:7]; m_rs1 = hw[19:15]; m_rs2 = hw[24:20];
                        m_imm = f_imm(hw); m_pc = e[31:0];
                    end
                end
                if (fv && exp_ready) m_q.push_back({inst, pc});
            end
        end
        @(posedge clk_in); #1;
        checks++;
        if ({iss_valid, illegal, iss_to_lsb, iss_order, iss_rd, iss_rs1, iss_rs2, iss_imm, iss_pc} !==
            {m_valid, m_ill, m_lsb, m_order, m_rd, m_rs1, m_rs2, m_imm, m_pc}) begin
            failures++;
            $display("FAIL issue_out @%0t got v=%b ill=%b lsb=%b ord=%0d rd=%0d rs1=%0d rs2=%0d imm=%h pc=%h exp v=%b ill=%b lsb=%b ord=%0d rd=%0d rs1=%0d rs2=%0d imm=%h pc=%h",
                     $time, iss_valid, illegal, iss_to_lsb, iss_order, iss_rd, iss_rs1, iss_rs2, iss_imm, iss_pc,
                     m_valid, m_ill, m_lsb, m_order, m_rd, m_rs1, m_rs2, m_imm, m_pc);
        end
        @(negedge clk_in);
    endtask

    task automatic idle(input logic robf);
        step(1'b0, 32'd0, 32'd0, robf, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic push(input logic [31:0] w, input logic [31:0] pc, input logic robf);
        step(1'b1, w, pc, robf, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0; rdy_in = 1'b1; fetch_valid = 1'b0; fetch_inst = 32'd0; fetch_pc = 32'd0;
        rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0; clear_in = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_in);
        checks++;
        if ({iss_valid, illegal, iss_to_lsb, iss_order, iss_rd, iss_rs1, iss_rs2, iss_imm, iss_pc, dec_inst} !== 121'd0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b ill=%b imm=%h pc=%h dec=%h exp all zero",
                     iss_valid, illegal, iss_imm, iss_pc, dec_inst);
        end
        rst_n_in = 1'b1;
        #1;
        checks++;
        if (fetch_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_fetch_ready got=%b exp=1", fetch_ready);
        end
        @(negedge clk_in);
    endtask

    task automatic test_addi();
        push(32'h00500093, 32'h0, 1'b0);
        idle(1'b0);
        checks++;
        if ({iss_valid, iss_to_lsb, iss_order, iss_rd, iss_rs1, iss_imm, iss_pc} !==
            {1'b1, 1'b0, O_ADDI, 5'd1, 5'd0, 32'd5, 32'd0}) begin
            failures++;
            $display("FAIL addi_issue got v=%b lsb=%b ord=%0d rd=%0d rs1=%0d imm=%h pc=%h exp v=1 lsb=0 ord=19 rd=1 rs1=0 imm=5 pc=0",
                     iss_valid, iss_to_lsb, iss_order, iss_rd, iss_rs1, iss_imm, iss_pc);
        end
    endtask

    task automatic test_lw_stall();
        step(1'b1, 32'h0040A103, 32'h4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            checks++;
            if (iss_valid !== 1'b0 || iss_pc !== 32'd0) begin
                failures++;
                $display("FAIL lw_stall cycle=%0d got v=%b pc=%h exp v=0 pc=0", i, iss_valid, iss_pc);
            end
        end
        idle(1'b0);
        checks++;
        if ({iss_valid, iss_to_lsb, iss_order, iss_rd, iss_rs1, iss_imm, iss_pc} !==
            {1'b1, 1'b1, O_LW, 5'd2, 5'd1, 32'd4, 32'd4}) begin
            failures++;
            $display("FAIL lw_issue got v=%b lsb=%b ord=%0d rd=%0d rs1=%0d imm=%h pc=%h exp v=1 lsb=1 ord=13 rd=2 rs1=1 imm=4 pc=4",
                     iss_valid, iss_to_lsb, iss_order, iss_rd, iss_rs1, iss_imm, iss_pc);
        end
    endtask

    task automatic test_fill_wrap();
        for (int i = 0; i < 16; i++)
            push({12'(i), 5'd0, 3'b000, 5'(i + 1), 7'b0010011}, 32'h100 + 32'(4 * i), 1'b1);
        checks++;
        if (fetch_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_ready got=%b exp=0", fetch_ready);
        end
        push(32'h00100093, 32'h200, 1'b1);
        for (int i = 0; i < 16; i++) begin
            idle(1'b0);
            checks++;
            if (iss_valid !== 1'b1 || iss_pc !== 32'h100 + 32'(4 * i) || iss_imm !== 32'(i)) begin
                failures++;
                $display("FAIL drain idx=%0d got v=%b pc=%h imm=%h exp v=1 pc=%h imm=%h",
                         i, iss_valid, iss_pc, iss_imm, 32'h100 + 32'(4 * i), 32'(i));
            end
        end
        idle(1'b0);
        checks++;
        if (iss_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_17th got v=%b pc=%h exp v=0", iss_valid, iss_pc);
        end
    endtask

    task automatic test_neg_imm_illegal();
        push(32'hFFF00093, 32'h8, 1'b0);
        idle(1'b0);
        checks++;
        if (iss_valid !== 1'b1 || iss_imm !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL neg_imm got v=%b imm=%h exp v=1 imm=ffffffff", iss_valid, iss_imm);
        end
        push(32'h00000000, 32'h300, 1'b0);
        push(32'h00700193, 32'h304, 1'b0);
        checks++;
        if (illegal !== 1'b1 || iss_valid !== 1'b0) begin
            failures++;
            $display("FAIL illegal_pulse got ill=%b v=%b exp ill=1 v=0", illegal, iss_valid);
        end
        idle(1'b0);
        checks++;
        if (illegal !== 1'b0 || iss_valid !== 1'b1 || iss_pc !== 32'h304 || iss_rd !== 5'd3) begin
            failures++;
            $display("FAIL after_illegal got ill=%b v=%b pc=%h rd=%0d exp ill=0 v=1 pc=304 rd=3",
                     illegal, iss_valid, iss_pc, iss_rd);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 5; i++) push(32'h00100093, 32'h400 + 32'(4 * i), 1'b1);
        step(1'b1, 32'h00200093, 32'h500, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (fetch_ready !== 1'b0 || iss_valid !== 1'b0 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL clear_flush got ready=%b v=%b ill=%b exp 0 0 0", fetch_ready, iss_valid, illegal);
        end
        step(1'b1, 32'h00300093, 32'h504, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (fetch_ready !== 1'b1 || dec_inst !== 32'd0 || iss_valid !== 1'b0) begin
            failures++;
            $display("FAIL clear_after got ready=%b dec=%h v=%b exp 1 0 0", fetch_ready, dec_inst, iss_valid);
        end
        push(32'h00900093, 32'h600, 1'b0);
        idle(1'b0);
        checks++;
        if (iss_valid !== 1'b1 || iss_pc !== 32'h600 || iss_imm !== 32'd9) begin
            failures++;
            $display("FAIL clear_new_push got v=%b pc=%h imm=%h exp v=1 pc=600 imm=9", iss_valid, iss_pc, iss_imm);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) push(32'h00100113, 32'h700 + 32'(4 * i), 1'b1);
        idle(1'b0);
        rst_n_in = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({iss_valid, illegal, iss_to_lsb, iss_order, iss_rd, iss_rs1, iss_rs2, iss_imm, iss_pc, dec_inst} !== 121'd0) begin
            failures++;
            $display("FAIL midreset_outputs got v=%b imm=%h pc=%h dec=%h exp all zero", iss_valid, iss_imm, iss_pc, dec_inst);
        end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        #1;
        checks++;
        if (fetch_ready !== 1'b1 || dec_inst !== 32'd0) begin
            failures++;
            $display("FAIL midreset_after got ready=%b dec=%h exp ready=1 dec=0", fetch_ready, dec_inst);
        end
        @(negedge clk_in);
        idle(1'b0);
    endtask

    function automatic logic [31:0] rand_word();
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] im;
        rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom); im = 12'($urandom);
        case ($urandom_range(0, 5))
            0: return {im, rs1, 3'b000, rd, 7'b0010011};
            1: return {im, rs1, 3'b010, rd, 7'b0000011};
            2: return {im, rs1, 3'b100, rd, 7'b0000011};
            3: return {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'b0100011};
            4: return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
            default: return ($urandom_range(0, 1) == 0) ? 32'd0 : {25'($urandom), 7'b1111111};
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] pc;
        pc = 32'h1000;
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) != 0), rand_word(), pc,
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 7) != 0));
            pc = pc + 32'd4;
        end
    endtask

    initial begin
        @(negedge clk_in);
        test_reset();
        test_addi();
        test_lw_stall();
        test_fill_wrap();
        test_neg_imm_illegal();
        test_clear();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
